// File: rtl/data_regen_multi_if.sv
// Bus bundle for the multi-lane sample reassembler.
// Handshake: DataValid is a one-cycle strobe with no backpressure (there is
// no ready); the consumer must take DataVector on every cycle DataValid=1.
// FrameVector/RawData are accepted unconditionally on every DivClk edge.
interface data_regen_multi_if #(
  parameter int SERDES_W = 8,
  parameter int NUM_CH   = 1,
  parameter int OUT_W    = 16,
  parameter int ERRCNT_W = 16
);
  logic [SERDES_W-1:0]        FrameVector;
  logic [NUM_CH*SERDES_W-1:0] RawData;
  logic [NUM_CH*OUT_W-1:0]    DataVector;
  logic                       DataValid;
  logic                       Locked;
  logic                       FrameErr;
  logic [ERRCNT_W-1:0]        ErrCnt;
  logic                       dbg_state;   // frame tracker state: 0 seek, 1 track

  modport master (
    output FrameVector, RawData,
    input  DataVector, DataValid, Locked, FrameErr, ErrCnt, dbg_state
  );

  modport slave (
    input  FrameVector, RawData,
    output DataVector, DataValid, Locked, FrameErr, ErrCnt, dbg_state
  );
endinterface

// File: rtl/data_regen_multi.sv
// Multi-lane sample reassembler: finds sample starts from frame-lane rising
// edges in the oldest of three buffered words, rebuilds SAMPLE_W-bit samples
// (first serial bit = MSB) and packs them into OUT_W-bit channel words.
// Tracks frame spacing for lock, flags framing errors and counts them.
module data_regen_multi #(
  parameter int SERDES_W = 8,
  parameter int SAMPLE_W = 12,
  parameter int OUT_W    = 16,
  parameter int NUM_CH   = 1,
  parameter int JUSTIFY  = 0,
  parameter int LOCK_CNT = 4,
  parameter int ERRCNT_W = 16
) (
  input logic          DivClk,
  input logic          Rst_n,
  data_regen_multi_if.slave bus
);
  localparam int POS_W = (SERDES_W > 1) ? $clog2(SERDES_W) : 1;
  localparam int GAP_W = $clog2(2 * SERDES_W);
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam int CAT_W = 3 * SERDES_W;
  localparam int DAT_W = NUM_CH * SERDES_W;

  typedef enum logic {S_SEEK, S_TRACK} track_t;

  // word history: index 0 newest, 2 oldest (evaluated)
  logic [SERDES_W-1:0] f0, f1, f2;
  logic                f_prev;      // serial bit just before f2[0]
  logic [DAT_W-1:0]    d0, d1, d2;

  track_t             state, state_n;
  logic [GAP_W-1:0]   gap, gap_n;   // required edge index relative to f2[0]
  logic [LCK_W-1:0]   lock_cnt, lock_n;

  logic [SERDES_W-1:0] edge_vec;
  logic                edge_found;
  logic [POS_W-1:0]    edge_pos;
  logic                err;
  logic                locked_n;
  logic                valid_n;
  logic [NUM_CH*OUT_W-1:0] vec_n;

  // shift the frame and data words through the three-deep history
  always_ff @(posedge DivClk) begin
    if (!Rst_n) begin
      f0 <= '0; f1 <= '0; f2 <= '0; f_prev <= 1'b0;
      d0 <= '0; d1 <= '0; d2 <= '0;
    end else begin
      f0 <= bus.FrameVector;
      f1 <= f0;
      f2 <= f1;
      f_prev <= f2[SERDES_W-1];
      d0 <= bus.RawData;
      d1 <= d0;
      d2 <= d1;
    end
  end

  // rising edge = bit set while its serial predecessor is clear
  assign edge_vec = f2 & ~{f2[SERDES_W-2:0], f_prev};

  // locate the (single) edge position within the oldest word
  always_comb begin
    edge_found = 1'b0;
    edge_pos   = '0;
    for (int i = 0; i < SERDES_W; i++) begin
      if (edge_vec[i] && !edge_found) begin
        edge_found = 1'b1;
        edge_pos   = POS_W'(i);
      end
    end
  end

  // tracker state register
  always_ff @(posedge DivClk) begin
    if (!Rst_n) begin
      state    <= S_SEEK;
      gap      <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      gap      <= gap_n;
      lock_cnt <= lock_n;
    end
  end

  // tracker next state: reference, spacing check, missing-edge detection
  always_comb begin
    state_n = state;
    gap_n   = gap;
    lock_n  = lock_cnt;
    err     = 1'b0;
    case (state)
      S_SEEK: begin
        if (edge_found) begin
          state_n = S_TRACK;
          lock_n  = LCK_W'(1);
          gap_n   = GAP_W'(edge_pos) + GAP_W'(SAMPLE_W - SERDES_W);
        end
      end
      S_TRACK: begin
        if (edge_found) begin
          gap_n = GAP_W'(edge_pos) + GAP_W'(SAMPLE_W - SERDES_W);
          if (GAP_W'(edge_pos) == gap) begin
            if (lock_cnt != LCK_W'(LOCK_CNT)) lock_n = lock_cnt + LCK_W'(1);
          end else begin
            err    = 1'b1;
            lock_n = LCK_W'(1);
          end
        end else if (gap < GAP_W'(SERDES_W)) begin
          err     = 1'b1;
          lock_n  = '0;
          state_n = S_SEEK;
        end else begin
          gap_n = gap - GAP_W'(SERDES_W);
        end
      end
      default: state_n = S_SEEK;
    endcase
  end

  assign locked_n = !err && (lock_n == LCK_W'(LOCK_CNT));
  assign valid_n  = edge_found && locked_n;

  // per-channel extraction: earliest serial bit becomes the sample MSB
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CAT_W-1:0]    cat;
    logic [SAMPLE_W-1:0] shifted;
    logic [OUT_W-1:0]    packed_word;

    assign cat     = {d0[g*SERDES_W +: SERDES_W], d1[g*SERDES_W +: SERDES_W],
                      d2[g*SERDES_W +: SERDES_W]};
    assign shifted = SAMPLE_W'(cat >> edge_pos);

    // bit-reverse into the justified position, unused bits zero
    always_comb begin
      packed_word = '0;
      for (int j = 0; j < SAMPLE_W; j++) begin
        if (JUSTIFY == 0) packed_word[OUT_W-1-j]    = shifted[j];
        else              packed_word[SAMPLE_W-1-j] = shifted[j];
      end
    end

    assign vec_n[g*OUT_W +: OUT_W] = packed_word;
  end

  // output stage: strobe, lock flag, error pulse and saturating counter
  always_ff @(posedge DivClk) begin
    if (!Rst_n) begin
      bus.DataVector <= '0;
      bus.DataValid  <= 1'b0;
      bus.Locked     <= 1'b0;
      bus.FrameErr   <= 1'b0;
      bus.ErrCnt     <= '0;
    end else begin
      bus.DataValid <= valid_n;
      bus.Locked    <= locked_n;
      bus.FrameErr  <= err;
      if (valid_n) bus.DataVector <= vec_n;
      if (err && (bus.ErrCnt != {ERRCNT_W{1'b1}})) bus.ErrCnt <= bus.ErrCnt + ERRCNT_W'(1);
    end
  end

  assign bus.dbg_state = (state == S_TRACK);
endmodule
